hwag_vr_gen: RTL and testbench
==============================

Name: hwag_vr_gen

Overview:
- Crank trigger-wheel signal generator: the transmitting end of the VR sensor interface that hwag decodes.
- Produces an N-minus-M toothed wheel waveform (e.g. 60-2) with programmable tooth period, for bench/HIL stimulus of hwag.vr_in and for self-test loopback on the FPGA.
- Sits beside hwag; config comes from ssram-mapped registers owned by the top level.

Parameters:
PERIOD_W, 24, width of tooth period in clk cycles (matches hwag PCNT width)
TOOTH_W, 8, width of tooth count fields (matches hwag TCNT width)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ena  in  1  generator enable; level-sensitive
cfg_period  in  PERIOD_W  clocks per tooth pitch P
cfg_teeth  in  TOOTH_W  total tooth positions N, including missing ones
cfg_missing  in  TOOTH_W  missing teeth M
cfg_load  in  1  one-clock strobe: capture cfg_* into the pending shadow
vr_gen  out  1  generated wheel signal; rising edge = tooth leading edge
tooth_num  out  TOOTH_W  index of the current real tooth, 0..N-M-1
rev_strobe  out  1  one-clock pulse on the first clock of tooth 0
gap_active  out  1  high during the gap interval
cfg_err  out  1  sticky: pending config invalid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; shadow and active config 0.
- Config shadowing: cfg_load copies cfg_* into pending regs. Pending is valid iff N>=2, M<N, and P>=2.
  - cfg_err is set on load of invalid config and cleared on load of valid config.
  - Active config is copied from pending only in IDLE, and at each revolution boundary (transition GAP->HIGH of tooth 0). It never changes mid-revolution.
- Phase split: H = P>>1 clocks high; L = P-H clocks low. For P=9: H=4, L=5.
- States:
  - IDLE: vr_gen=0. If ena=1 and pending is valid, latch active config; next clock enters HIGH with tooth_num=0, vr_gen=1, rev_strobe=1.
  - HIGH: vr_gen=1 for H clocks, then LOW.
  - LOW: vr_gen=0 for L clocks. Then:
    - if tooth_num < N-M-1: increment tooth_num and enter HIGH;
    - otherwise: enter GAP if M>0, else wrap as a revolution boundary.
  - GAP: vr_gen=0, gap_active=1 for M*P clocks. Then revolution boundary: tooth_num=0, rev_strobe=1, enter HIGH.
- Revolution length = N*P clocks exactly.
- The period counter and the gap length M*P use PERIOD_W+TOOTH_W bits internally; no overflow is possible.
- Phase counter counts 0..len-1. Transition happens on the clock where count==len-1.
- ena=0 in any state: next clock enters IDLE, vr_gen=0, gap_active=0, tooth_num=0. No partial-tooth completion.
- ena=1 with invalid pending config: remain in IDLE.
- cfg_load during run with a valid config: takes effect at the next revolution boundary. An invalid load mid-run sets cfg_err and the current active config continues.
- Simultaneous cfg_load and boundary on the same clock: the boundary copies the pre-load pending value; the new value applies at the following boundary.
- All outputs are registered (no combinational paths from inputs to outputs).

Decomposition:
- Shared package hwag_pkg: state enum (IDLE, HIGH, LOW, GAP); PERIOD_W/TOOTH_W defaults; wheel constants (default 60-2, ACNT top 3839).
- One sub-module: hwag_vr_gen_cfg, holding the pending/active shadow regs, the validity check, cfg_err, and the boundary copy.
- FSM and phase counter live in the top of this block.

Test Plan:
- P=8, N=6, M=1, load then ena=1 -> vr_gen: 5 teeth of 4 high/4 low, then 8 clocks low with gap_active=1. rev_strobe every 48 clocks; tooth_num cycles 0..4.
- P=9, N=4, M=0 -> each tooth 4 high/5 low; no gap_active; rev_strobe period 36.
- Load P=16 mid-revolution of a P=8 run -> the current revolution stays at P=8; the first tooth-0 after the boundary is 8 high/8 low.
- Load N=4, M=4 -> cfg_err=1, stays IDLE, vr_gen=0. Then load a valid config -> cfg_err=0 and the generator starts.
- Drop ena during GAP, and separately assert rst low mid-HIGH -> vr_gen=0 and busy=0 (next clock for ena; immediately for rst). Re-enable -> restarts at tooth 0 with rev_strobe.
- Loopback into hwag with P=200, N=60, M=2, edge0 = rising -> hwag_start asserts after the first gap is detected; hwag TCNT tracks tooth_num.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared definitions for the hwag crank-wheel blocks.
// Holds the default field widths, the reference wheel geometry and the
// generator FSM state type.
package hwag_pkg;

    // Default widths: tooth period counter and tooth count fields.
    localparam int unsigned DefPeriodW = 24;
    localparam int unsigned DefToothW  = 8;

    // Reference wheel: 60-2, angle counter top = 60 * 64 - 1.
    localparam int unsigned WheelTeeth   = 60;
    localparam int unsigned WheelMissing = 2;
    localparam int unsigned AcntTop      = 3839;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StGap
    } vr_state_e;

endpackage

// File: rtl/hwag_vr_gen_if.sv
// Control/config and status bundle of the trigger-wheel generator.
//   master: drives ena and cfg_*, observes the wheel outputs.
//   slave : the generator side.
interface hwag_vr_gen_if
    import hwag_pkg::*;
#(
    parameter int unsigned PERIOD_W = DefPeriodW,
    parameter int unsigned TOOTH_W  = DefToothW
) ();
    logic                ena;
    logic [PERIOD_W-1:0] cfg_period;
    logic [TOOTH_W-1:0]  cfg_teeth;
    logic [TOOTH_W-1:0]  cfg_missing;
    logic                cfg_load;
    logic                vr_gen;
    logic [TOOTH_W-1:0]  tooth_num;
    logic                rev_strobe;
    logic                gap_active;
    logic                cfg_err;
    logic                busy;

    modport master (
        output ena, cfg_period, cfg_teeth, cfg_missing, cfg_load,
        input  vr_gen, tooth_num, rev_strobe, gap_active, cfg_err, busy
    );

    modport slave (
        input  ena, cfg_period, cfg_teeth, cfg_missing, cfg_load,
        output vr_gen, tooth_num, rev_strobe, gap_active, cfg_err, busy
    );
endinterface

// File: rtl/hwag_vr_gen_cfg.sv
// Configuration shadowing for the trigger-wheel generator.
// load_i captures the requested config into a pending set and checks it.
// copy_i moves pending into the active set, but only if pending is valid,
// so an invalid load never disturbs a running wheel.
// Ports: clk/rst, load_i + period_i/teeth_i/missing_i (request),
//        copy_i (start or revolution boundary), pend_valid_o,
//        act_*_o (config in use), cfg_err_o (sticky until a valid load).
module hwag_vr_gen_cfg #(
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned TOOTH_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [TOOTH_W-1:0]  teeth_i,
    input  logic [TOOTH_W-1:0]  missing_i,
    input  logic                copy_i,
    output logic                pend_valid_o,
    output logic [PERIOD_W-1:0] act_period_o,
    output logic [TOOTH_W-1:0]  act_teeth_o,
    output logic [TOOTH_W-1:0]  act_missing_o,
    output logic                cfg_err_o
);
    logic [PERIOD_W-1:0] pend_period_q, act_period_q;
    logic [TOOTH_W-1:0]  pend_teeth_q, pend_missing_q, act_teeth_q, act_missing_q;
    logic                pend_valid_q, cfg_err_q;
    logic                load_valid;

    assign load_valid = (teeth_i >= TOOTH_W'(2)) && (missing_i < teeth_i) &&
                        (period_i >= PERIOD_W'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_period_q  <= '0;
            pend_teeth_q   <= '0;
            pend_missing_q <= '0;
            pend_valid_q   <= 1'b0;
            cfg_err_q      <= 1'b0;
            act_period_q   <= '0;
            act_teeth_q    <= '0;
            act_missing_q  <= '0;
        end else begin
            // Copy reads the pre-load pending value when both strobe together.
            if (copy_i && pend_valid_q) begin
                act_period_q  <= pend_period_q;
                act_teeth_q   <= pend_teeth_q;
                act_missing_q <= pend_missing_q;
            end
            if (load_i) begin
                pend_period_q  <= period_i;
                pend_teeth_q   <= teeth_i;
                pend_missing_q <= missing_i;
                pend_valid_q   <= load_valid;
                cfg_err_q      <= !load_valid;
            end
        end
    end

    assign pend_valid_o  = pend_valid_q;
    assign act_period_o  = act_period_q;
    assign act_teeth_o   = act_teeth_q;
    assign act_missing_o = act_missing_q;
    assign cfg_err_o     = cfg_err_q;
endmodule

// File: rtl/hwag_vr_gen.sv
// Crank trigger-wheel generator: emits an N-minus-M toothed wheel with
// P clocks per tooth pitch (P>>1 high, the rest low, then M*P clocks of gap).
// Ports: clk, rst (async, active low), bus (slave modport: ena, cfg_* in;
//        vr_gen, tooth_num, rev_strobe, gap_active, cfg_err, busy out).
// All outputs come straight from flops.
module hwag_vr_gen
    import hwag_pkg::*;
#(
    parameter int unsigned PERIOD_W = DefPeriodW,
    parameter int unsigned TOOTH_W  = DefToothW
) (
    input  logic          clk,
    input  logic          rst,
    hwag_vr_gen_if.slave  bus
);
    // Wide enough for M*P, so the gap length cannot overflow.
    localparam int unsigned CntW = PERIOD_W + TOOTH_W;

    vr_state_e           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [TOOTH_W-1:0]  tooth_q, tooth_d;
    logic                rev_q, rev_d;
    logic                vr_q, gap_q, busy_q;
    logic                rev_start;

    logic                pend_valid;
    logic [PERIOD_W-1:0] act_period;
    logic [TOOTH_W-1:0]  act_teeth, act_missing, last_tooth;
    logic [CntW-1:0]     hi_len, lo_len, gap_len;

    hwag_vr_gen_cfg #(
        .PERIOD_W (PERIOD_W),
        .TOOTH_W  (TOOTH_W)
    ) u_cfg (
        .clk           (clk),
        .rst           (rst),
        .load_i        (bus.cfg_load),
        .period_i      (bus.cfg_period),
        .teeth_i       (bus.cfg_teeth),
        .missing_i     (bus.cfg_missing),
        .copy_i        (rev_start),
        .pend_valid_o  (pend_valid),
        .act_period_o  (act_period),
        .act_teeth_o   (act_teeth),
        .act_missing_o (act_missing),
        .cfg_err_o     (bus.cfg_err)
    );

    assign hi_len     = CntW'(act_period >> 1);
    assign lo_len     = CntW'(act_period) - hi_len;
    assign gap_len    = CntW'(act_missing) * CntW'(act_period);
    assign last_tooth = act_teeth - act_missing - TOOTH_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        tooth_d   = tooth_q;
        rev_d     = 1'b0;
        rev_start = 1'b0;
        if (!bus.ena) begin
            state_d = StIdle;
            cnt_d   = '0;
            tooth_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (pend_valid) rev_start = 1'b1;
                end
                StHigh: begin
                    if (cnt_q == hi_len - CntW'(1)) begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end
                end
                StLow: begin
                    if (cnt_q == lo_len - CntW'(1)) begin
                        cnt_d = '0;
                        if (tooth_q < last_tooth) begin
                            tooth_d = tooth_q + TOOTH_W'(1);
                            state_d = StHigh;
                        end else if (act_missing != '0) begin
                            state_d = StGap;
                        end else begin
                            rev_start = 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (cnt_q == gap_len - CntW'(1)) rev_start = 1'b1;
                end
                default: state_d = StIdle;
            endcase
            // Start from IDLE and revolution boundary share one path: tooth 0.
            if (rev_start) begin
                state_d = StHigh;
                cnt_d   = '0;
                tooth_d = '0;
                rev_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tooth_q <= '0;
            rev_q   <= 1'b0;
            vr_q    <= 1'b0;
            gap_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tooth_q <= tooth_d;
            rev_q   <= rev_d;
            vr_q    <= (state_d == StHigh);
            gap_q   <= (state_d == StGap);
            busy_q  <= (state_d != StIdle);
        end
    end

    assign bus.vr_gen     = vr_q;
    assign bus.tooth_num  = tooth_q;
    assign bus.rev_strobe = rev_q;
    assign bus.gap_active = gap_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_hwag_vr_gen.sv
module tb_hwag_vr_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hwag_vr_gen_if bus ();

    hwag_vr_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: position within the revolution, in clocks.
    bit run;
    int pos;
    int ap, an, am;
    bit mpv, merr;
    int mpp, mpn, mpm;
    // Current requested config for directed stimulus.
    int cur_p, cur_n, cur_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        run = 0; pos = 0; ap = 0; an = 0; am = 0;
        mpv = 0; merr = 0; mpp = 0; mpn = 0; mpm = 0;
    endtask

    task automatic model_edge(input bit en, input bit ld, input int p, input int n, input int m);
        bit pv = mpv;
        int pp = mpp, pn = mpn, pm = mpm;
        if (!en) begin
            run = 0;
        end else if (!run) begin
            if (pv) begin
                run = 1; pos = 0; ap = pp; an = pn; am = pm;
            end
        end else begin
            pos++;
            if (pos == an * ap) begin
                pos = 0;
                if (pv) begin
                    ap = pp; an = pn; am = pm;
                end
            end
        end
        if (ld) begin
            mpp = p; mpn = n; mpm = m;
            mpv = (n >= 2) && (m < n) && (p >= 2);
            merr = !mpv;
        end
    endtask

    task automatic compare_all();
        int real_t, e_tooth;
        bit e_vr, e_gap, e_rev, e_busy;
        e_tooth = 0; e_vr = 0; e_gap = 0; e_rev = 0; e_busy = 0;
        if (run) begin
            real_t  = an - am;
            e_tooth = (pos / ap < real_t - 1) ? pos / ap : real_t - 1;
            e_gap   = (pos >= real_t * ap);
            e_vr    = !e_gap && ((pos % ap) < (ap / 2));
            e_rev   = (pos == 0);
            e_busy  = 1;
        end
        check_eq("vr_gen", 32'(bus.vr_gen), 32'(e_vr));
        check_eq("tooth_num", 32'(bus.tooth_num), 32'(e_tooth));
        check_eq("rev_strobe", 32'(bus.rev_strobe), 32'(e_rev));
        check_eq("gap_active", 32'(bus.gap_active), 32'(e_gap));
        check_eq("busy", 32'(bus.busy), 32'(e_busy));
        check_eq("cfg_err", 32'(bus.cfg_err), 32'(merr));
    endtask

    // Called at a negedge; returns at the following negedge after checking.
    task automatic step(input bit en, input bit ld, input int p, input int n, input int m);
        bus.ena         = en;
        bus.cfg_load    = ld;
        bus.cfg_period  = p[23:0];
        bus.cfg_teeth   = n[7:0];
        bus.cfg_missing = m[7:0];
        @(posedge clk);
        model_edge(en, ld, p, n, m);
        @(negedge clk);
        compare_all();
    endtask

    task automatic load(input bit en, input int p, input int n, input int m);
        cur_p = p; cur_n = n; cur_m = m;
        step(en, 1'b1, p, n, m);
    endtask

    task automatic run_for(input bit en, input int cycles);
        for (int i = 0; i < cycles; i++) step(en, 1'b0, cur_p, cur_n, cur_m);
    endtask

    initial begin
        model_reset();
        cur_p = 0; cur_n = 0; cur_m = 0;
        bus.ena = 0; bus.cfg_load = 0; bus.cfg_period = '0;
        bus.cfg_teeth = '0; bus.cfg_missing = '0;
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b1;

        // 60-style small wheel: 6-1, P=8.
        load(1'b0, 8, 6, 1);
        run_for(1'b1, 100);
        // M=0 wheel, P=9 (odd split), applied at next boundary.
        load(1'b1, 9, 4, 0);
        run_for(1'b1, 110);
        // Period change mid-revolution.
        load(1'b1, 8, 6, 1);
        run_for(1'b1, 60);
        load(1'b1, 16, 6, 1);
        run_for(1'b1, 200);

        // Invalid config while idle: stays idle, cfg_err set.
        run_for(1'b0, 3);
        load(1'b0, 8, 4, 4);
        run_for(1'b1, 20);
        load(1'b1, 8, 6, 1);
        run_for(1'b1, 30);
        // Drop ena inside the gap.
        for (int i = 0; i < 100 && !(run && pos >= (an - am) * ap); i++) run_for(1'b1, 1);
        check_eq("reached_gap", 32'(run && pos >= (an - am) * ap), 32'd1);
        run_for(1'b0, 3);
        run_for(1'b1, 50);
        // Invalid load mid-run keeps the active wheel.
        load(1'b1, 5, 4, 4);
        run_for(1'b1, 120);

        // Async reset in the middle of a high phase.
        load(1'b1, 10, 5, 1);
        run_for(1'b1, 15);
        for (int i = 0; i < 100 && !(run && pos > ap && (pos % ap) < ap / 2); i++)
            run_for(1'b1, 1);
        check_eq("reached_high", 32'(run && (pos % ap) < ap / 2), 32'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_eq("rst_vr_gen", 32'(bus.vr_gen), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        compare_all();
        rst = 1'b1;
        load(1'b1, 10, 5, 1);
        run_for(1'b1, 60);

        // Randomized configs, loads and enable drops.
        for (int i = 0; i < 3000; i++) begin
            bit en = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 79) == 0)
                load(en, $urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 8));
            else
                step(en, 1'b0, cur_p, cur_n, cur_m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
